// File: rtl/ca_cfar_detector.sv
// Cell-averaging CFAR detector: a sliding window over range-cell power with incrementally
// maintained lead/lag reference sums. Each result appears a fixed three clocks after its sample.
module ca_cfar_detector #(
    parameter int DW         = 25,
    parameter int NREF       = 16,
    parameter int LOG2_NREF  = 4,
    parameter int NGUARD     = 2,
    parameter int ALPHA_W    = 8,
    parameter int ALPHA_FRAC = 4,
    parameter int RANGE_W    = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              prt_start,
    input  logic                              in_valid,
    input  logic [DW-1:0]                     in_pow,
    input  logic [ALPHA_W-1:0]                alpha,
    output logic                              out_valid,
    output logic [DW-1:0]                     out_pow,
    output logic [DW+ALPHA_W-ALPHA_FRAC-1:0]  out_thr,
    output logic                              out_det,
    output logic [RANGE_W-1:0]                out_range
);

    localparam int L      = 2*NREF + 2*NGUARD + 1;
    localparam int CUT    = NREF + NGUARD;
    localparam int LAG_IN = NREF + 2*NGUARD;
    localparam int SW     = DW + LOG2_NREF;
    localparam int TW     = DW + ALPHA_W - ALPHA_FRAC;
    localparam int PW     = DW + ALPHA_W;
    localparam int FW     = $clog2(L + 1);

    localparam logic [FW-1:0]      FILL_FULL = FW'(L);
    localparam logic [RANGE_W-1:0] RANGE_MAX = '1;

    // Stage 1: delay line, reference sums and counters
    logic [DW-1:0]      tap       [L];
    logic [DW-1:0]      tap_next  [L];
    logic [DW-1:0]      base_tap  [L];
    logic [SW-1:0]      lead, lead_next, base_lead;
    logic [SW-1:0]      lag, lag_next, base_lag;
    logic [FW-1:0]      fill_cnt, fill_next, base_fill;
    logic [RANGE_W-1:0] range_cnt, range_next, base_range;
    logic               window_full;
    logic               v1;
    logic [ALPHA_W-1:0] alpha1;
    logic [RANGE_W-1:0] range1;

    // Stage 2: noise estimate and CUT
    logic [SW:0]        ref_total;
    logic               v2;
    logic [DW-1:0]      noise2;
    logic [DW-1:0]      cut2;
    logic [ALPHA_W-1:0] alpha2;
    logic [RANGE_W-1:0] range2;

    // Stage 3: scaled threshold
    logic [PW-1:0]      product;
    logic               v3;
    logic [TW-1:0]      thr3;
    logic [DW-1:0]      pow3;
    logic [RANGE_W-1:0] range3;

    // prt_start clears first, so a sample in the same cycle lands in an empty window as range 0.
    always_comb begin
        // NOTE: every signal driven here gets a default before any condition, so no latch is inferred.
        for (int i = 0; i < L; i++) begin
            base_tap[i] = prt_start ? '0 : tap[i];
        end
        base_lead  = prt_start ? '0 : lead;
        base_lag   = prt_start ? '0 : lag;
        base_fill  = prt_start ? '0 : fill_cnt;
        base_range = prt_start ? '0 : range_cnt;

        tap_next    = base_tap;
        lead_next   = base_lead;
        lag_next    = base_lag;
        fill_next   = base_fill;
        range_next  = base_range;
        window_full = 1'b0;

        if (in_valid) begin
            tap_next[0] = in_pow;
            for (int i = 1; i < L; i++) begin
                tap_next[i] = base_tap[i-1];
            end
            lead_next   = base_lead + SW'(in_pow) - SW'(base_tap[NREF-1]);
            lag_next    = base_lag + SW'(base_tap[LAG_IN]) - SW'(base_tap[L-1]);
            fill_next   = (base_fill == FILL_FULL) ? FILL_FULL : base_fill + FW'(1);
            range_next  = (base_range == RANGE_MAX) ? RANGE_MAX : base_range + RANGE_W'(1);
            window_full = (fill_next == FILL_FULL);
        end
    end

    assign ref_total = {1'b0, lead} + {1'b0, lag};
    assign product   = PW'(noise2) * PW'(alpha2);

    // The product is registered ahead of the compare so the multiplier has a cycle to itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the delay line is reset along with the sums; the incremental sums are only
            // correct while they agree with the taps they subtract.
            for (int i = 0; i < L; i++) begin
                tap[i] <= '0;
            end
            lead      <= '0;
            lag       <= '0;
            fill_cnt  <= '0;
            range_cnt <= '0;
            v1        <= 1'b0;
            alpha1    <= '0;
            range1    <= '0;
            v2        <= 1'b0;
            noise2    <= '0;
            cut2      <= '0;
            alpha2    <= '0;
            range2    <= '0;
            v3        <= 1'b0;
            thr3      <= '0;
            pow3      <= '0;
            range3    <= '0;
            out_valid <= 1'b0;
            out_pow   <= '0;
            out_thr   <= '0;
            out_det   <= 1'b0;
            out_range <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every stage samples the previous cycle's state.
            tap       <= tap_next;
            lead      <= lead_next;
            lag       <= lag_next;
            fill_cnt  <= fill_next;
            range_cnt <= range_next;
            v1        <= window_full;
            if (in_valid) begin
                alpha1 <= alpha;
                range1 <= base_range - RANGE_W'(CUT);
            end

            v2 <= v1;
            if (v1) begin
                noise2 <= ref_total[LOG2_NREF+1 +: DW];
                cut2   <= tap[CUT];
                alpha2 <= alpha1;
                range2 <= range1;
            end

            v3 <= v2;
            if (v2) begin
                thr3   <= product[ALPHA_FRAC +: TW];
                pow3   <= cut2;
                range3 <= range2;
            end

            out_valid <= v3;
            if (v3) begin
                out_pow   <= pow3;
                out_thr   <= thr3;
                out_det   <= {{(TW-DW){1'b0}}, pow3} > thr3;
                out_range <= range3;
            end
        end
    end

endmodule

// File: tb/tb_ca_cfar_detector.sv
// Self-checking bench for ca_cfar_detector: a window-level reference model predicts every
// output cycle, and directed scenarios pin known thresholds, ranges and latencies.
module tb_ca_cfar_detector;

    localparam int DW      = 25;
    localparam int ALPHA_W = 8;
    localparam int TW      = 29;
    localparam int RANGE_W = 12;
    localparam int L       = 37;
    localparam logic [DW-1:0] PMAX = 25'h1FF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               prt_start = 1'b0;
    logic               in_valid = 1'b0;
    logic [DW-1:0]      in_pow = '0;
    logic [ALPHA_W-1:0] alpha = 8'h30;
    logic               out_valid;
    logic [DW-1:0]      out_pow;
    logic [TW-1:0]      out_thr;
    logic               out_det;
    logic [RANGE_W-1:0] out_range;

    always #5 clk = ~clk;

    ca_cfar_detector dut (
        .clk       (clk),
        .rst       (rst),
        .prt_start (prt_start),
        .in_valid  (in_valid),
        .in_pow    (in_pow),
        .alpha     (alpha),
        .out_valid (out_valid),
        .out_pow   (out_pow),
        .out_thr   (out_thr),
        .out_det   (out_det),
        .out_range (out_range)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int                 due;
        logic [DW-1:0]      pow;
        logic [TW-1:0]      thr;
        logic               det;
        logic [RANGE_W-1:0] rng;
    } res_t;

    typedef struct {
        int                 cyc;
        logic [DW-1:0]      pow;
        logic [TW-1:0]      thr;
        logic               det;
        logic [RANGE_W-1:0] rng;
    } obs_t;

    res_t          expq[$];
    res_t          hold;
    logic [DW-1:0] win[$];
    obs_t          seq[$];
    obs_t          obs;
    logic          exp_v;
    int            cyc = 0;
    int            next_idx = 0;
    int            acc36 = 0;

    // win[0] is the oldest cell of a full window and win[L-1] the newest.
    function automatic res_t model_result(input int due, input int newest, input logic [ALPHA_W-1:0] a);
        longint unsigned ref_sum = 0;
        longint unsigned noise;
        longint unsigned thr;
        res_t r;
        for (int i = 0; i < 16; i++) begin
            ref_sum += longint'(win[i]);
            ref_sum += longint'(win[L-1-i]);
        end
        noise = ref_sum / 32;
        thr   = noise * a / 16;
        r.due = due;
        r.pow = win[18];
        r.thr = TW'(thr);
        r.det = longint'(win[18]) > thr;
        r.rng = RANGE_W'(newest - 18);
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            win.delete();
            expq.delete();
            next_idx = 0;
            hold = '{default: 0};
        end else begin
            if (prt_start) begin
                win.delete();
                next_idx = 0;
            end
            if (in_valid) begin
                win.push_back(in_pow);
                if (win.size() > L) void'(win.pop_front());
                if (win.size() == L) expq.push_back(model_result(cyc + 3, next_idx, alpha));
                if (next_idx < 4095) next_idx++;
            end
        end
    end

    // Outputs hold their last result between strobes, so every field is checked every cycle.
    always @(negedge clk) begin
        exp_v = (expq.size() > 0) && (expq[0].due == cyc);
        if (exp_v) hold = expq.pop_front();
        check("out_valid", out_valid, exp_v);
        check("out_pow", out_pow, hold.pow);
        check("out_thr", out_thr, hold.thr);
        check("out_det", out_det, hold.det);
        check("out_range", out_range, hold.rng);
        if (out_valid === 1'b1) begin
            obs.cyc = cyc;
            obs.pow = out_pow;
            obs.thr = out_thr;
            obs.det = out_det;
            obs.rng = out_range;
            seq.push_back(obs);
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] p, input logic ps = 1'b0, input logic r = 1'b1);
        rst = r;
        prt_start = ps;
        in_valid = v;
        in_pow = p;
        @(posedge clk);
        #1;
        rst = 1'b1;
        prt_start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic feed(input int n, input logic [DW-1:0] val, input int spike_at,
                        input logic [DW-1:0] spike_val, input int max_gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, (i == spike_at) ? spike_val : val);
            if (i == 36) acc36 = cyc;
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
        end
    endtask

    task automatic check_range(input string name, input int r, input logic [DW-1:0] pow,
                               input logic [TW-1:0] thr, input logic det);
        int k = -1;
        foreach (seq[i]) if (k < 0 && seq[i].rng == RANGE_W'(r)) k = i;
        if (k < 0) begin
            n_checks++;
            $display("FAIL %s: range %0d never produced", name, r);
        end else begin
            check({name, " pow"}, seq[k].pow, pow);
            check({name, " thr"}, seq[k].thr, thr);
            check({name, " det"}, seq[k].det, det);
        end
    endtask

    task automatic spike_checks(input string tag);
        check({tag, " count"}, seq.size(), 28);
        check_range({tag, " cut"}, 30, 1000, 300, 1'b1);
        check_range({tag, " guard28"}, 28, 100, 300, 1'b0);
        check_range({tag, " guard29"}, 29, 100, 300, 1'b0);
        check_range({tag, " guard31"}, 31, 100, 300, 1'b0);
        check_range({tag, " guard32"}, 32, 100, 300, 1'b0);
        check_range({tag, " lead18"}, 18, 100, 384, 1'b0);
        check_range({tag, " lead27"}, 27, 100, 384, 1'b0);
        check_range({tag, " lag33"}, 33, 100, 384, 1'b0);
        check_range({tag, " lag45"}, 45, 100, 384, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("reset out_valid", out_valid, 0);
        check("reset out_pow", out_pow, 0);
        check("reset out_thr", out_thr, 0);
        check("reset out_det", out_det, 0);
        check("reset out_range", out_range, 0);

        // Flat PRT: every covered cell sees the same noise floor.
        seq.delete();
        step(1'b0, '0, 1'b1);
        feed(64, 100, -1, 0, 0);
        idle(6);
        check("s1 count", seq.size(), 28);
        check("s1 first range", seq[0].rng, 18);
        check("s1 last range", seq[27].rng, 45);
        check("s1 latency", seq[0].cyc - acc36, 3);
        foreach (seq[i]) begin
            check("s1 thr", seq[i].thr, 300);
            check("s1 det", seq[i].det, 0);
        end

        seq.delete();
        step(1'b0, '0, 1'b1);
        feed(64, 100, 30, 1000, 0);
        idle(6);
        spike_checks("s2");

        seq.delete();
        step(1'b0, '0, 1'b1);
        feed(64, 100, 30, 1000, 5);
        idle(6);
        spike_checks("s3");

        // A new PRT starts with a sample on the same cycle as prt_start.
        seq.delete();
        step(1'b0, '0, 1'b1);
        feed(50, 100, -1, 0, 0);
        step(1'b1, 200, 1'b1);
        feed(39, 200, -1, 0, 0);
        idle(6);
        check("s4 count", seq.size(), 18);
        check("s4 old last range", seq[13].rng, 31);
        check("s4 new first range", seq[14].rng, 18);
        check("s4 new first thr", seq[14].thr, 600);
        check("s4 new last range", seq[17].rng, 21);

        // Reset mid-stream with prt_start and a sample present: reset wins.
        seq.delete();
        step(1'b0, '0, 1'b1);
        feed(45, 100, -1, 0, 0);
        step(1'b1, 100, 1'b1, 1'b0);
        check("s5 out_valid", out_valid, 0);
        check("s5 out_pow", out_pow, 0);
        check("s5 out_thr", out_thr, 0);
        check("s5 out_range", out_range, 0);
        idle(5);
        check("s5 dropped in-flight", seq.size(), 6);
        feed(40, 100, -1, 0, 0);
        idle(6);
        check("s5 count", seq.size(), 10);
        check("s5 first range", seq[6].rng, 18);
        check("s5 first thr", seq[6].thr, 300);

        // Full-scale input: largest threshold, then the equality case.
        seq.delete();
        step(1'b0, '0, 1'b1);
        alpha = 8'hFF;
        feed(40, PMAX, -1, 0, 0);
        alpha = 8'h10;
        feed(10, PMAX, -1, 0, 0);
        idle(6);
        alpha = 8'h30;
        check("s6 count", seq.size(), 14);
        check("s6 max thr", seq[0].thr, 534773744);
        check("s6 max det", seq[0].det, 0);
        check("s6 max thr last", seq[3].thr, 534773744);
        check("s6 unity thr", seq[4].thr, PMAX);
        check("s6 unity thr last", seq[13].thr, PMAX);
        check("s6 unity det", seq[13].det, 0);
        check("s6 unity pow", seq[13].pow, PMAX);

        // Random traffic: gaps, mixed magnitudes, per-sample alpha, sporadic PRTs and resets.
        for (int n = 0; n < 3000; n++) begin
            alpha = ALPHA_W'($urandom_range(255, 0));
            step($urandom_range(9, 0) < 7,
                 ($urandom_range(3, 0) == 0) ? DW'($urandom()) : DW'($urandom_range(3000, 0)),
                 $urandom_range(99, 0) == 0,
                 $urandom_range(999, 0) != 0);
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
